// File: rtl/vec_issue_frontend_if.sv
// Issue stream between the vector frontend and the OVI bridge.
// The frontend drives the queue head; the bridge answers with OVI_HALT back-pressure.
interface vec_issue_frontend_if #(
  parameter int VL_WIDTH = 14
);
  logic                ISSUE_VALID;
  logic [31:0]         ISSUE_INSTR;
  logic [VL_WIDTH-1:0] ISSUE_VL;
  logic [1:0]          ISSUE_SEW;
  logic                OVI_HALT;

  modport master (
    output ISSUE_VALID,
    output ISSUE_INSTR,
    output ISSUE_VL,
    output ISSUE_SEW,
    input  OVI_HALT
  );

  modport slave (
    input  ISSUE_VALID,
    input  ISSUE_INSTR,
    input  ISSUE_VL,
    input  ISSUE_SEW,
    output OVI_HALT
  );
endinterface

// File: rtl/vec_issue_frontend.sv
// Vector issue frontend: retires vsetvli locally and queues every other vector
// instruction with a snapshot of the vl/sew in force when it was accepted.
module vec_issue_frontend #(
  parameter int DEPTH    = 4,
  parameter int VLEN     = 512,
  parameter int VL_WIDTH = 14
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     INSTR_VALID,
  input  logic [31:0]              INSTR,
  input  logic [63:0]              RS1_DATA,
  output logic                     INSTR_READY,
  output logic                     VSETVL_DONE,
  output logic [63:0]              VSETVL_RESULT,
  output logic                     ILLEGAL,
  output logic [$clog2(DEPTH):0]   QUEUE_COUNT,
  vec_issue_frontend_if.master     issue
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]         mem_instr [DEPTH];
  logic [VL_WIDTH-1:0] mem_vl    [DEPTH];
  logic [1:0]          mem_sew   [DEPTH];

  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;
  logic [VL_WIDTH-1:0] vl_q;
  logic [1:0]          sew_q;
  logic                done_q;
  logic                illegal_q;
  logic [63:0]         result_q;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                is_vsetvli;
  logic                is_queued;
  logic                accept;
  logic                enq;
  logic                fire;
  logic                not_empty;
  logic [1:0]          new_sew;
  logic [63:0]         vlmax;
  logic [63:0]         avl;
  logic [63:0]         vl_min;
  logic [VL_WIDTH-1:0] new_vl;

  assign opcode      = INSTR[6:0];
  assign funct3      = INSTR[14:12];
  assign not_empty   = (count != '0);
  assign INSTR_READY = (count != FULL_CNT);
  assign accept      = INSTR_VALID & INSTR_READY;
  assign enq         = accept & is_queued;
  assign fire        = not_empty & ~issue.OVI_HALT;

  // Decode and the vsetvli vl rule; min() is taken at full 64 bits before truncation.
  always_comb begin
    is_vsetvli = 1'b0;
    is_queued  = 1'b0;
    if (opcode == 7'b1010111) begin
      if (funct3 == 3'b111) is_vsetvli = ~INSTR[31];
      else                  is_queued  = 1'b1;
    end else if (opcode == 7'b0000111 || opcode == 7'b0100111) begin
      is_queued = (funct3 == 3'b000) || (funct3 == 3'b101) ||
                  (funct3 == 3'b110) || (funct3 == 3'b111);
    end

    new_sew = INSTR[23:22];
    vlmax   = 64'(VLEN) >> (7'd3 + {5'd0, new_sew});
    avl     = (INSTR[19:15] != 5'd0) ? RS1_DATA : vlmax;
    vl_min  = (avl < vlmax) ? avl : vlmax;
    if (INSTR[19:15] == 5'd0 && INSTR[11:7] == 5'd0) new_vl = vl_q;
    else                                             new_vl = VL_WIDTH'(vl_min);
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      mem_instr[tail] <= INSTR;
      mem_vl[tail]    <= vl_q;
      mem_sew[tail]   <= sew_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      vl_q      <= '0;
      sew_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q    <= accept & is_vsetvli;
      illegal_q <= accept & ~is_vsetvli & ~is_queued;
      if (accept && is_vsetvli) begin
        vl_q     <= new_vl;
        sew_q    <= new_sew;
        result_q <= 64'(new_vl);
      end
      if (enq)  tail <= tail + 1'b1;
      if (fire) head <= head + 1'b1;
      // Simultaneous enqueue and fire leaves the occupancy unchanged.
      case ({enq, fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign VSETVL_DONE       = done_q;
  assign VSETVL_RESULT     = result_q;
  assign ILLEGAL           = illegal_q;
  assign QUEUE_COUNT       = count;
  assign issue.ISSUE_VALID = not_empty;
  assign issue.ISSUE_INSTR = not_empty ? mem_instr[head] : '0;
  assign issue.ISSUE_VL    = not_empty ? mem_vl[head]    : '0;
  assign issue.ISSUE_SEW   = not_empty ? mem_sew[head]   : '0;
endmodule

// File: tb/tb_vec_issue_frontend.sv
// Directed and random stimulus for vec_issue_frontend, checked against a
// queue-based reference model of the vl/sew rules and issue stream.
module tb_vec_issue_frontend;
  localparam int DEPTH    = 4;
  localparam int VLEN     = 512;
  localparam int VL_WIDTH = 14;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic              CLK;
  logic              RST;
  logic              INSTR_VALID;
  logic [31:0]       INSTR;
  logic [63:0]       RS1_DATA;
  logic              INSTR_READY;
  logic              VSETVL_DONE;
  logic [63:0]       VSETVL_RESULT;
  logic              ILLEGAL;
  logic [CNT_W-1:0]  QUEUE_COUNT;

  vec_issue_frontend_if #(.VL_WIDTH(VL_WIDTH)) bus ();

  vec_issue_frontend #(.DEPTH(DEPTH), .VLEN(VLEN), .VL_WIDTH(VL_WIDTH)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .INSTR_VALID   (INSTR_VALID),
    .INSTR         (INSTR),
    .RS1_DATA      (RS1_DATA),
    .INSTR_READY   (INSTR_READY),
    .VSETVL_DONE   (VSETVL_DONE),
    .VSETVL_RESULT (VSETVL_RESULT),
    .ILLEGAL       (ILLEGAL),
    .QUEUE_COUNT   (QUEUE_COUNT),
    .issue         (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0]     instr;
    longint unsigned vl;
    int unsigned     sew;
  } entry_t;

  entry_t          mq[$];
  longint unsigned mvl;
  int unsigned     msew;
  bit              mdone;
  bit              millegal;
  longint unsigned mresult;
  int              total = 0;
  int              bad   = 0;

  function automatic logic [31:0] mkVsetvli(logic [4:0] rd, logic [4:0] rs1, logic [1:0] sew);
    logic [31:0] w;
    w = '0;
    w[23:22] = sew;
    w[19:15] = rs1;
    w[14:12] = 3'b111;
    w[11:7]  = rd;
    w[6:0]   = 7'h57;
    return w;
  endfunction

  function automatic logic [31:0] mkOpv(logic [2:0] f3, logic [5:0] tag);
    return {tag, 1'b1, 5'd2, 5'd1, f3, 5'd4, 7'h57};
  endfunction

  function automatic logic [31:0] mkLoad(logic [4:0] rd);
    return {3'b000, 1'b0, 2'b00, 1'b1, 5'd0, 5'd10, 3'b000, rd, 7'h07};
  endfunction

  // 0 = vsetvli, 1 = queued vector op, 2 = illegal
  function automatic int classifyM(logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    if (op == 7'h57) return (f3 == 3'd7) ? (w[31] ? 2 : 0) : 1;
    if (op == 7'h07 || op == 7'h27) return (f3 == 3'd0 || f3 >= 3'd5) ? 1 : 2;
    return 2;
  endfunction

  function automatic logic [31:0] genRandInstr();
    logic [31:0] w;
    logic [2:0]  ls_f3 [4];
    int          kind;
    ls_f3 = '{3'd0, 3'd5, 3'd6, 3'd7};
    kind  = int'($urandom_range(0, 9));
    w     = $urandom;
    if (kind <= 2) begin
      w = mkVsetvli(5'($urandom_range(0, 2)), 5'($urandom_range(0, 1) * $urandom_range(1, 31)),
                    2'($urandom_range(0, 3)));
    end else if (kind <= 4) begin
      w[6:0]   = ($urandom_range(0, 1) != 0) ? 7'h07 : 7'h27;
      w[14:12] = ls_f3[$urandom_range(0, 3)];
    end else if (kind <= 7) begin
      w[6:0]   = 7'h57;
      w[14:12] = 3'($urandom_range(0, 6));
    end else if (kind == 8) begin
      w = mkVsetvli(5'd1, 5'd5, 2'd0);
      w[31] = 1'b1;
    end
    return w;
  endfunction

  task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compareAll();
    checkOutput("ready", 64'(INSTR_READY), 64'(mq.size() < DEPTH));
    checkOutput("count", 64'(QUEUE_COUNT), 64'(mq.size()));
    checkOutput("issue_valid", 64'(bus.ISSUE_VALID), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      checkOutput("issue_instr", 64'(bus.ISSUE_INSTR), 64'(mq[0].instr));
      checkOutput("issue_vl", 64'(bus.ISSUE_VL), 64'(mq[0].vl));
      checkOutput("issue_sew", 64'(bus.ISSUE_SEW), 64'(mq[0].sew));
    end
    checkOutput("vsetvl_done", 64'(VSETVL_DONE), 64'(mdone));
    if (mdone) checkOutput("vsetvl_result", VSETVL_RESULT, mresult);
    checkOutput("illegal", 64'(ILLEGAL), 64'(millegal));
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, compare just after.
  task automatic applyStimulus(bit rst, bit valid, logic [31:0] instr, logic [63:0] rs1, bit halt);
    bit              ready_m;
    bit              fire_m;
    int unsigned     s;
    longint unsigned vlmax;
    longint unsigned avl;
    longint unsigned nvl;
    @(negedge CLK);
    RST          = rst;
    INSTR_VALID  = valid;
    INSTR        = instr;
    RS1_DATA     = rs1;
    bus.OVI_HALT = halt;
    @(posedge CLK);
    ready_m = mq.size() < DEPTH;
    fire_m  = (mq.size() != 0) && !halt;
    if (rst) begin
      mq.delete();
      mvl = 0; msew = 0; mdone = 0; millegal = 0; mresult = 0;
    end else begin
      mdone = 0;
      millegal = 0;
      if (fire_m) void'(mq.pop_front());
      if (valid && ready_m) begin
        case (classifyM(instr))
          0: begin
            s     = int'(instr[23:22]);
            vlmax = longint'(VLEN / (8 << s));
            if (instr[19:15] == 0 && instr[11:7] == 0) nvl = mvl;
            else begin
              avl = (instr[19:15] != 0) ? rs1 : vlmax;
              nvl = (avl < vlmax) ? avl : vlmax;
            end
            mvl = nvl % (64'd1 << VL_WIDTH);
            msew = s;
            mdone = 1;
            mresult = mvl;
          end
          1: mq.push_back('{instr, mvl, msew});
          default: millegal = 1;
        endcase
      end
    end
    #1;
    compareAll();
  endtask

  logic [63:0] rnd_rs1;

  initial begin
    $display("[TB] start");
    applyStimulus(1, 0, '0, '0, 0);
    applyStimulus(1, 1, mkOpv(3'd0, 6'd1), 64'd5, 0);
    checkOutput("rst_result", VSETVL_RESULT, 64'd0);
    checkOutput("rst_issue_instr", 64'(bus.ISSUE_INSTR), 64'd0);
    checkOutput("rst_issue_vl", 64'(bus.ISSUE_VL), 64'd0);

    // vsetvli e32 with AVL 100 clamps to VLMAX 16
    applyStimulus(0, 1, mkVsetvli(5'd1, 5'd5, 2'd2), 64'd100, 0);
    checkOutput("t1_result", VSETVL_RESULT, 64'd16);
    checkOutput("t1_count", 64'(QUEUE_COUNT), 64'd0);

    applyStimulus(0, 1, mkVsetvli(5'd1, 5'd0, 2'd0), 64'd7, 0);
    applyStimulus(0, 1, mkLoad(5'd3), 64'd0, 0);
    checkOutput("t2_vl", 64'(bus.ISSUE_VL), 64'd64);
    checkOutput("t2_instr", 64'(bus.ISSUE_INSTR), 64'(mkLoad(5'd3)));
    applyStimulus(0, 0, '0, '0, 0);

    // Fill while halted, refuse a fifth, then drain in order
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, mkOpv(3'd0, 6'(10 + i)), 64'd0, 1);
    checkOutput("t3_full_count", 64'(QUEUE_COUNT), 64'd4);
    checkOutput("t3_full_ready", 64'(INSTR_READY), 64'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, '0, 0);
    checkOutput("t3_drained", 64'(QUEUE_COUNT), 64'd0);

    // Steady count of two with simultaneous push and fire across a wrap
    applyStimulus(0, 1, mkOpv(3'd1, 6'd20), 64'd0, 1);
    applyStimulus(0, 1, mkOpv(3'd1, 6'd21), 64'd0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, mkOpv(3'd2, 6'(22 + i)), 64'd0, 0);
    checkOutput("t4_count", 64'(QUEUE_COUNT), 64'd2);
    applyStimulus(0, 0, '0, '0, 0);
    applyStimulus(0, 0, '0, '0, 0);

    applyStimulus(0, 1, mkVsetvli(5'd2, 5'd5, 2'd3), 64'd3, 0);
    applyStimulus(0, 1, mkOpv(3'd0, 6'd0), 64'd0, 0);
    checkOutput("t5_vl_a", 64'(bus.ISSUE_VL), 64'd3);
    checkOutput("t5_sew_a", 64'(bus.ISSUE_SEW), 64'd3);
    applyStimulus(0, 1, mkVsetvli(5'd0, 5'd0, 2'd1), 64'd999, 0);
    applyStimulus(0, 1, mkOpv(3'd0, 6'd0), 64'd0, 0);
    checkOutput("t5_vl_b", 64'(bus.ISSUE_VL), 64'd3);
    checkOutput("t5_sew_b", 64'(bus.ISSUE_SEW), 64'd1);
    applyStimulus(0, 0, '0, '0, 0);

    applyStimulus(0, 1, 32'h0020_81b3, 64'd0, 0);
    checkOutput("t6_illegal_op", 64'(ILLEGAL), 64'd1);
    applyStimulus(0, 1, mkVsetvli(5'd1, 5'd5, 2'd0) | 32'h8000_0000, 64'd1, 0);
    checkOutput("t6_illegal_vsetvl", 64'(ILLEGAL), 64'd1);
    applyStimulus(0, 0, '0, '0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, mkOpv(3'd3, 6'(40 + i)), 64'd0, 1);
    applyStimulus(1, 0, '0, '0, 1);
    checkOutput("t6_rst_valid", 64'(bus.ISSUE_VALID), 64'd0);
    checkOutput("t6_rst_count", 64'(QUEUE_COUNT), 64'd0);

    for (int i = 0; i < 400; i++) begin
      rnd_rs1 = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 600));
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, genRandInstr(),
                    rnd_rs1, $urandom_range(0, 9) < 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
